// File: rtl/conv2d_pad_stride_stream.sv
// Streaming 2D convolution: loads an NxN image and MxM kernel, then emits the
// OxO zero-padded, strided, saturated results in raster order with backpressure.
module conv2d_pad_stride_stream #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 40,
   parameter int unsigned MAX_N  = 16,
   parameter int unsigned MAX_M  = 5,
   parameter int unsigned DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DIM_W-1:0]  n_i,
   input  logic [DIM_W-1:0]  m_i,
   input  logic [DIM_W-1:0]  s_i,
   input  logic [DIM_W-1:0]  p_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_last_o,
   output logic              done_o,
   output logic              cfg_err_o
);

   localparam int unsigned EXT_W = DIM_W + 2;
   localparam int unsigned CW    = 2 * DIM_W + 4;
   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned IA_W  = $clog2(MAX_N * MAX_N);
   localparam int unsigned KA_W  = $clog2(MAX_M * MAX_M);
   localparam int unsigned LW    = $clog2(MAX_N * MAX_N + MAX_M * MAX_M + 1);

   localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StEmit, StFin} state_e;

   state_e                   state_q;
   logic [DIM_W-1:0]         n_q, m_q, s_q, p_q;
   logic [EXT_W-1:0]         o_q, r_q, c_q;
   logic [DIM_W-1:0]         ki_q, kj_q;
   logic [LW-1:0]            ld_q;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     in_ready_q, out_valid_q, out_last_q, done_q, cfg_err_q;
   logic [DATA_W-1:0]        out_data_q;

   logic signed [DATA_W-1:0] img_mem [MAX_N*MAX_N];
   logic signed [DATA_W-1:0] ker_mem [MAX_M*MAX_M];

   // Config check and output-side computation for the job being started
   logic [EXT_W-1:0] span, div, o_cfg;
   logic             cfg_bad;

   always_comb begin
      span    = EXT_W'(n_i) + (EXT_W'(p_i) << 1);
      cfg_bad = (n_i == '0) || (m_i == '0) || (s_i == '0) ||
                (EXT_W'(n_i) > EXT_W'(MAX_N)) || (EXT_W'(m_i) > EXT_W'(MAX_M)) ||
                (EXT_W'(m_i) > span);
      div     = (s_i == '0) ? EXT_W'(1) : EXT_W'(s_i);
      o_cfg   = (span - EXT_W'(m_i)) / div + EXT_W'(1);
   end

   logic [LW-1:0] nn, ld_end;
   logic          beat;

   always_comb begin
      nn     = LW'(n_q) * LW'(n_q);
      ld_end = nn + LW'(m_q) * LW'(m_q) - LW'(1);
      beat   = (state_q == StLoad) && in_valid_i && in_ready_q;
   end

   always_ff @(posedge clk) begin
      if (beat) begin
         if (ld_q < nn) img_mem[IA_W'(ld_q)] <= in_data_i;
         else           ker_mem[KA_W'(ld_q - nn)] <= in_data_i;
      end
   end

   // Image coordinate of the current tap; a negative value wraps to a set MSB
   logic [CW-1:0]            iy, ix;
   logic                     in_rng, k_last, o_last;
   logic signed [DATA_W-1:0] img_rd, ker_rd;
   logic signed [PW-1:0]     prod;
   logic [DATA_W-1:0]        sat;

   always_comb begin
      iy     = CW'(r_q) * CW'(s_q) + CW'(ki_q) - CW'(p_q);
      ix     = CW'(c_q) * CW'(s_q) + CW'(kj_q) - CW'(p_q);
      in_rng = !iy[CW-1] && !ix[CW-1] && (iy < CW'(n_q)) && (ix < CW'(n_q));
      img_rd = img_mem[IA_W'(iy * CW'(n_q) + ix)];
      ker_rd = ker_mem[KA_W'(CW'(ki_q) * CW'(m_q) + CW'(kj_q))];
      prod   = img_rd * ker_rd;
      acc_d  = acc_q + (in_rng ? {{(ACC_W-PW){prod[PW-1]}}, prod} : '0);
      k_last = (ki_q == m_q - 1'b1) && (kj_q == m_q - 1'b1);
      o_last = (r_q == o_q - 1'b1) && (c_q == o_q - 1'b1);
      if (acc_d > SMAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
      else if (acc_d < SMIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
      else                   sat = acc_d[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         n_q         <= '0;
         m_q         <= '0;
         s_q         <= '0;
         p_q         <= '0;
         o_q         <= '0;
         r_q         <= '0;
         c_q         <= '0;
         ki_q        <= '0;
         kj_q        <= '0;
         ld_q        <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (cfg_bad) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     n_q        <= n_i;
                     m_q        <= m_i;
                     s_q        <= s_i;
                     p_q        <= p_i;
                     o_q        <= o_cfg;
                     ld_q       <= '0;
                     r_q        <= '0;
                     c_q        <= '0;
                     ki_q       <= '0;
                     kj_q       <= '0;
                     acc_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (beat) begin
                  ld_q <= ld_q + 1'b1;
                  if (ld_q == ld_end) begin
                     in_ready_q <= 1'b0;
                     state_q    <= StMac;
                  end
               end
            end
            StMac: begin
               acc_q <= acc_d;
               if (kj_q == m_q - 1'b1) begin
                  kj_q <= '0;
                  ki_q <= (ki_q == m_q - 1'b1) ? '0 : ki_q + 1'b1;
               end else begin
                  kj_q <= kj_q + 1'b1;
               end
               if (k_last) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= sat;
                  out_last_q  <= o_last;
                  state_q     <= StEmit;
               end
            end
            StEmit: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  acc_q       <= '0;
                  if (o_last) begin
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     state_q <= StMac;
                     if (c_q == o_q - 1'b1) begin
                        c_q <= '0;
                        r_q <= r_q + 1'b1;
                     end else begin
                        c_q <= c_q + 1'b1;
                     end
                  end
               end
            end
            StFin: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign done_o      = done_q;
   assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_conv2d_pad_stride_stream.sv
// Scoreboard bench for conv2d_pad_stride_stream: directed jobs push expected results,
// an independent monitor pops and compares on every accepted output.
module tb_conv2d_pad_stride_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  n_cfg, m_cfg, s_cfg, p_cfg;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready_o;
   logic [15:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready;
   logic        out_last_o;
   logic        done_o;
   logic        cfg_err_o;

   always #5 clk = ~clk;

   conv2d_pad_stride_stream dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .n_i         (n_cfg),
      .m_i         (m_cfg),
      .s_i         (s_cfg),
      .p_i         (p_cfg),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready),
      .out_last_o  (out_last_o),
      .done_o      (done_o),
      .cfg_err_o   (cfg_err_o)
   );

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   img_q[$];
   int   ker_q[$];
   int   exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   stall_mode = 1'b0;
   bit   held_v = 1'b0;
   int   held_d;
   bit   held_l;
   bit   done_pend = 1'b0;
   exp_t e;

   task automatic check(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Sink: always ready, or in stall mode hold ready low 5 cycles per result
   initial begin
      int cnt = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_mode) begin
            out_ready = 1'b1;
         end else if (out_valid_o) begin
            if (cnt < 5) begin
               out_ready = 1'b0;
               cnt++;
            end else begin
               out_ready = 1'b1;
               cnt = 0;
            end
         end else begin
            out_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v    = 1'b0;
            done_pend = 1'b0;
         end else begin
            if (done_pend) begin
               check("done_pulse", int'(done_o), 1);
               done_pend = 1'b0;
            end else if (done_o) begin
               check("spurious_done", int'(done_o), 0);
            end
            if (out_valid_o) begin
               if (held_v) begin
                  check("hold_data", int'($signed(out_data_o)), held_d);
                  check("hold_last", int'(out_last_o), int'(held_l));
               end
               if (out_ready) begin
                  held_v = 1'b0;
                  if (sb.size() == 0) begin
                     check("unexpected_out", sb.size(), 1);
                  end else begin
                     e = sb.pop_front();
                     check("out_data", int'($signed(out_data_o)), e.data);
                     check("out_last", int'(out_last_o), int'(e.last));
                     if (e.last) done_pend = 1'b1;
                  end
               end else begin
                  held_v = 1'b1;
                  held_d = int'($signed(out_data_o));
                  held_l = out_last_o;
               end
            end
         end
      end
   end

   task automatic start_job(input int n, input int m, input int s, input int p);
      n_cfg = 6'(n);
      m_cfg = 6'(m);
      s_cfg = 6'(s);
      p_cfg = 6'(p);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("in_ready_load", int'(in_ready_o), 1);
   endtask

   task automatic load(input bit gaps);
      int words[$];
      words = {img_q, ker_q};
      foreach (words[i]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 16'hdead;
               @(posedge clk);
               #1;
            end
         end
         in_data  = 16'(words[i]);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("in_ready_after_load", int'(in_ready_o), 0);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done_o && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("done_seen", int'(done_o), 1);
      @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
   endtask

   task automatic run_job(input int n, input int m, input int s, input int p, input bit gaps);
      exp_t x;
      foreach (exp_q[i]) begin
         x.data = exp_q[i];
         x.last = (i == exp_q.size() - 1);
         sb.push_back(x);
      end
      start_job(n, m, s, p);
      load(gaps);
      wait_done();
   endtask

   task automatic set_t1();
      img_q = {};
      for (int i = 1; i <= 9; i++) img_q.push_back(i);
      ker_q = {1, 1, 1, 1};
      exp_q = {12, 16, 24, 28};
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      n_cfg    = '0;
      m_cfg    = '0;
      s_cfg    = '0;
      p_cfg    = '0;
      in_data  = '0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_flags", int'({in_ready_o, out_valid_o, out_last_o, done_o, cfg_err_o}), 0);
      check("rst_data", int'(out_data_o), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1 basic
      set_t1();
      run_job(3, 2, 1, 0, 1'b0);

      // T2 padding
      img_q = {1, 2, 3, 4};
      ker_q = {1, 1, 1, 1, 1, 1, 1, 1, 1};
      exp_q = {10, 10, 10, 10};
      run_job(2, 3, 1, 1, 1'b0);

      // T3 stride
      img_q = {};
      for (int i = 1; i <= 16; i++) img_q.push_back(i);
      ker_q = {1, 1, 1, 1};
      exp_q = {14, 22, 46, 54};
      run_job(4, 2, 2, 0, 1'b0);

      // T4 saturation both ways
      img_q = {32767, 32767, 32767, 32767};
      ker_q = {32767, 32767, 32767, 32767};
      exp_q = {32767};
      run_job(2, 2, 1, 0, 1'b0);
      ker_q = {-32768, -32768, -32768, -32768};
      exp_q = {-32768};
      run_job(2, 2, 1, 0, 1'b0);

      // Stride beyond span gives a single output
      set_t1();
      exp_q = {12};
      run_job(3, 2, 5, 0, 1'b0);

      // M == N+2P gives a single output
      img_q = {5};
      ker_q = {1, 1, 1, 1, 1, 1, 1, 1, 1};
      exp_q = {5};
      run_job(1, 3, 1, 1, 1'b0);

      // Padding-only windows produce zero
      img_q = {7};
      ker_q = {2};
      exp_q = {0, 0, 0, 0, 14, 0, 0, 0, 0};
      run_job(1, 1, 1, 1, 1'b0);

      // T5 handshake: input gaps plus output stalls
      stall_mode = 1'b1;
      set_t1();
      run_job(3, 2, 1, 0, 1'b1);
      stall_mode = 1'b0;
      @(posedge clk);
      #1;

      // T6 illegal configs: S=0, M>MAX_M, M>N+2P
      for (int k = 0; k < 3; k++) begin
         n_cfg = (k == 2) ? 6'd2 : 6'd8;
         m_cfg = (k == 1) ? 6'd6 : 6'd3;
         s_cfg = (k == 0) ? 6'd0 : 6'd1;
         p_cfg = 6'd0;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         check("cfg_err_pulse", int'(cfg_err_o), 1);
         check("cfg_err_no_load", int'(in_ready_o), 0);
         @(posedge clk);
         #1;
         check("cfg_err_clear", int'({cfg_err_o, in_ready_o}), 0);
      end

      // Reset mid-MAC aborts the job, then a clean rerun
      set_t1();
      start_job(3, 2, 1, 0);
      load(1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_flags", int'({in_ready_o, out_valid_o, out_last_o, done_o, cfg_err_o}), 0);
      check("midrst_data", int'(out_data_o), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_t1();
      run_job(3, 2, 1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
